eth_tx_arbiter: RTL and testbench

//  Shares the single RMII transmit datapath between two packet sources (e.g. logic-analyzer

---
 rtl/eth_pkg.sv | 13 +
 rtl/eth_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and limits for the Ethernet RMII transmit path.
package eth_pkg;

   typedef enum logic [1:0] {TXA_IDLE, TXA_GRANT, TXA_SEND, TXA_GAP} txa_state_t;

   typedef logic [1:0] dibit_t;

   localparam int ETH_IFG_DIBITS    = 48;
   localparam int ETH_START_TIMEOUT = 64;
   localparam int ETH_MAX_DIBITS    = 6104;
   localparam int ETH_CNT_W         = 13;

endpackage

// File: rtl/eth_tx_arbiter.sv
// Per-packet round-robin share of the RMII TX datapath between two sources; 1-cycle registered pass-through.
// No backpressure: a granted source streams freely, guarded by start-timeout, max-length cut and forced gap.
module eth_tx_arbiter
   import eth_pkg::*;
#(
   parameter int IFG_DIBITS    = ETH_IFG_DIBITS,
   parameter int START_TIMEOUT = ETH_START_TIMEOUT,
   parameter int MAX_DIBITS    = ETH_MAX_DIBITS
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   req0,
   input  logic   req1,
   output logic   gnt0,
   output logic   gnt1,
   input  logic   axii0v,
   input  dibit_t axii0d,
   input  logic   axii1v,
   input  dibit_t axii1d,
   output logic   axiov,
   output dibit_t axiod,
   output logic   busy,
   output logic   err_trunc,
   output logic   err_tmo
);

   localparam logic [ETH_CNT_W-1:0] IFG_LAST = ETH_CNT_W'(IFG_DIBITS - 1);
   localparam logic [ETH_CNT_W-1:0] TMO_LAST = ETH_CNT_W'(START_TIMEOUT - 1);
   localparam logic [ETH_CNT_W-1:0] MAX_CNT  = ETH_CNT_W'(MAX_DIBITS);
   localparam logic [ETH_CNT_W-1:0] CNT_SAT  = {ETH_CNT_W{1'b1}};

   txa_state_t             state_q, state_d;
   logic                   last_q, last_d;
   logic [ETH_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic                   gnt0_q, gnt0_d;
   logic                   gnt1_q, gnt1_d;
   logic                   axiov_q, axiov_d;
   dibit_t                 axiod_q, axiod_d;
   logic                   err_trunc_q, err_trunc_d;
   logic                   err_tmo_q, err_tmo_d;

   logic                   any_req;
   logic                   pick;
   logic                   sel_v;
   dibit_t                 sel_d;

   // last_q doubles as the owner of the current grant once it has been issued
   assign any_req = req0 | req1;
   assign pick    = (req0 & req1) ? ~last_q : req1;
   assign sel_v   = last_q ? axii1v : axii0v;
   assign sel_d   = last_q ? axii1d : axii0d;
   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + ETH_CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= TXA_IDLE;
         last_q      <= 1'b1;
         cnt_q       <= '0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         axiov_q     <= 1'b0;
         axiod_q     <= 2'b00;
         err_trunc_q <= 1'b0;
         err_tmo_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         axiov_q     <= axiov_d;
         axiod_q     <= axiod_d;
         err_trunc_q <= err_trunc_d;
         err_tmo_q   <= err_tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         TXA_IDLE: begin
            if (any_req) begin
               state_d = TXA_GRANT;
               last_d  = pick;
               cnt_d   = '0;
            end
         end
         TXA_GRANT: begin
            if (sel_v) begin
               state_d = TXA_SEND;
               cnt_d   = ETH_CNT_W'(1);
            end else if (cnt_q == TMO_LAST) begin
               state_d = TXA_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         TXA_SEND: begin
            // cnt_q holds dibits already forwarded; a valid one past the limit cuts the packet
            if (!sel_v || cnt_q == MAX_CNT) begin
               state_d = TXA_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         TXA_GAP: begin
            if (cnt_q == IFG_LAST) begin
               state_d = TXA_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         default: begin
            state_d = TXA_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      axiov_d     = 1'b0;
      axiod_d     = 2'b00;
      err_trunc_d = 1'b0;
      err_tmo_d   = 1'b0;
      case (state_q)
         TXA_IDLE: begin
            gnt0_d = any_req & ~pick;
            gnt1_d = any_req & pick;
         end
         TXA_GRANT: begin
            if (sel_v) begin
               gnt0_d  = ~last_q;
               gnt1_d  = last_q;
               axiov_d = 1'b1;
               axiod_d = sel_d;
            end else if (cnt_q == TMO_LAST) begin
               err_tmo_d = 1'b1;
            end else begin
               gnt0_d = ~last_q;
               gnt1_d = last_q;
            end
         end
         TXA_SEND: begin
            if (sel_v && cnt_q != MAX_CNT) begin
               gnt0_d  = ~last_q;
               gnt1_d  = last_q;
               axiov_d = 1'b1;
               axiod_d = sel_d;
            end else if (sel_v) begin
               err_trunc_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign axiov     = axiov_q;
   assign axiod     = axiod_q;
   assign busy      = (state_q != TXA_IDLE);
   assign err_trunc = err_trunc_q;
   assign err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: random packets against a packet-level model of grant order, forwarding and gaps.
module tb_eth_tx_arbiter;

   localparam int IFG  = 48;
   localparam int TMO  = 64;
   localparam int MAXD = 6104;

   logic       clk, rst;
   logic       req0, req1, gnt0, gnt1;
   logic       axii0v, axii1v, axiov, busy, err_trunc, err_tmo;
   logic [1:0] axii0d, axii1d, axiod;

   int checks = 0;
   int errors = 0;
   int model_last = 1;

   eth_tx_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
      .axii0v(axii0v), .axii0d(axii0d), .axii1v(axii1v), .axii1d(axii1d),
      .axiov(axiov), .axiod(axiod), .busy(busy),
      .err_trunc(err_trunc), .err_tmo(err_tmo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int src, input logic v, input logic [1:0] d);
      if (src == 0) begin axii0v = v; axii0d = d; end
      else          begin axii1v = v; axii1d = d; end
   endtask

   task automatic wait_grant(output int w);
      w = 0;
      while (!(gnt0 || gnt1) && w < 200) begin
         tick();
         w++;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      drive(0, 1'b0, 2'b00);
      drive(1, 1'b0, 2'b00);
      tick();
      tick();
      rst = 1'b0;
      model_last = 1;
   endtask

   // One packet from whichever source the model expects to win, checked cycle by cycle:
   // dibit s shows up one cycle after it is driven, at most MAXD are forwarded, then IFG idle cycles.
   task automatic run_pkt(input int len, input int pat, input bit noise, output int w);
      int src, nexp, last_s, bad, first_bad, fwd, ntr;
      logic [1:0] d, g_exp;
      logic [1:0] sent[$];
      logic exp_v, exp_b, exp_tr;
      src   = (req0 && req1) ? ((model_last == 1) ? 0 : 1) : (req1 ? 1 : 0);
      g_exp = (src == 1) ? 2'b10 : 2'b01;
      wait_grant(w);
      checks++;
      if ({gnt1, gnt0} !== g_exp) begin
         errors++;
         $display("FAIL grant_src: gnt=%b required=%b after %0d cycles", {gnt1, gnt0}, g_exp, w);
         return;
      end
      model_last = src;
      if (src == 0) req0 = 1'b0; else req1 = 1'b0;
      nexp   = (len < MAXD) ? len : MAXD;
      last_s = (len - 1 > nexp + IFG) ? len - 1 : nexp + IFG;
      bad = 0; first_bad = -1; fwd = 0; ntr = 0;
      for (int s = 0; s <= last_s; s++) begin
         d = (pat < 0) ? 2'($urandom_range(0, 3)) : 2'(pat);
         sent.push_back(d);
         drive(src, s < len, d);
         if (noise) drive(1 - src, 1'($urandom_range(0, 1)), 2'b11);
         tick();
         exp_v  = (s < nexp);
         exp_b  = (s < nexp + IFG);
         exp_tr = (len > MAXD) && (s == nexp);
         if (axiov === 1'b1) fwd++;
         if (err_trunc === 1'b1) ntr++;
         if (axiov !== exp_v || axiod !== (exp_v ? sent[s] : 2'b00) ||
             {gnt1, gnt0} !== (exp_v ? g_exp : 2'b00) || busy !== exp_b ||
             err_trunc !== exp_tr || err_tmo !== 1'b0) begin
            bad++;
            if (first_bad < 0) first_bad = s;
         end
      end
      drive(0, 1'b0, 2'b00);
      drive(1, 1'b0, 2'b00);
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL pkt_cycles src=%0d len=%0d: %0d cycles off model (first at %0d), required 0", src, len, bad, first_bad);
      end
      checks++;
      if (fwd != nexp) begin
         errors++;
         $display("FAIL pkt_fwd_count src=%0d len=%0d: got %0d, required %0d", src, len, fwd, nexp);
      end
      checks++;
      if (ntr != ((len > MAXD) ? 1 : 0)) begin
         errors++;
         $display("FAIL pkt_trunc_pulses len=%0d: got %0d, required %0d", len, ntr, (len > MAXD) ? 1 : 0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      drive(0, 1'b0, 2'b00);
      drive(1, 1'b0, 2'b00);
      tick();
      tick();
      checks++;
      if ({gnt0, gnt1, axiov, axiod, busy, err_trunc, err_tmo} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got %b, required 00000000", {gnt0, gnt1, axiov, axiod, busy, err_trunc, err_tmo});
      end
      rst = 1'b0;
      model_last = 1;
      tick();
      checks++;
      if ({gnt0, gnt1, busy} !== 3'b000) begin
         errors++;
         $display("FAIL idle_no_req: gnt0,gnt1,busy=%b, required 000", {gnt0, gnt1, busy});
      end
   endtask

   task automatic test_single();
      int w;
      apply_reset();
      req0 = 1'b1;
      run_pkt(100, 2, 1'b0, w);
      checks++;
      if (w != 1) begin
         errors++;
         $display("FAIL single_grant_latency: %0d cycles, required 1", w);
      end
   endtask

   task automatic test_round_robin();
      int w, r;
      apply_reset();
      req0 = 1'b1; req1 = 1'b1;
      run_pkt($urandom_range(1, 40), -1, 1'b0, w);
      run_pkt($urandom_range(1, 40), -1, 1'b0, w);
      checks++;
      if (w != 1) begin
         errors++;
         $display("FAIL rr_back_to_back: next grant after %0d cycles, required 1", w);
      end
      req0 = 1'b1; req1 = 1'b1;
      run_pkt($urandom_range(1, 40), -1, 1'b0, w);
      for (int i = 0; i < 6; i++) begin
         r = $urandom_range(1, 3);
         req0 = r[0]; req1 = r[1];
         run_pkt($urandom_range(1, 60), -1, 1'($urandom_range(0, 1)), w);
         checks++;
         if (w != 1) begin
            errors++;
            $display("FAIL rr_random_latency[%0d]: %0d cycles, required 1", i, w);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_noise();
      int w;
      req0 = 1'b1;
      run_pkt(60, -1, 1'b1, w);
   endtask

   task automatic test_timeout();
      int w, bad, ntmo;
      req0 = 1'b1; req1 = 1'b0;
      wait_grant(w);
      checks++;
      if ({gnt1, gnt0} !== 2'b01) begin
         errors++;
         $display("FAIL tmo_grant: gnt=%b, required 01", {gnt1, gnt0});
      end
      model_last = 0;
      req0 = 1'b0;
      bad = 0; ntmo = 0;
      for (int t = 1; t <= TMO + IFG; t++) begin
         tick();
         if (err_tmo === 1'b1) ntmo++;
         if ({gnt1, gnt0} !== ((t < TMO) ? 2'b01 : 2'b00) || err_tmo !== (t == TMO) ||
             busy !== (t < TMO + IFG) || axiov !== 1'b0 || axiod !== 2'b00 || err_trunc !== 1'b0)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL tmo_cycles: %0d cycles off model, required 0", bad);
      end
      checks++;
      if (ntmo != 1) begin
         errors++;
         $display("FAIL tmo_pulses: got %0d, required 1", ntmo);
      end
   endtask

   task automatic test_trunc();
      int w;
      req0 = 1'b1; req1 = 1'b0;
      run_pkt(6200, -1, 1'b0, w);
      req1 = 1'b1;
      run_pkt(20, -1, 1'b0, w);
      checks++;
      if (w != 1) begin
         errors++;
         $display("FAIL trunc_next_src1: grant after %0d cycles, required 1", w);
      end
   endtask

   task automatic test_rst_mid();
      int w, bad;
      logic [1:0] d;
      req0 = 1'b1; req1 = 1'b0;
      wait_grant(w);
      checks++;
      if ({gnt1, gnt0} !== 2'b01) begin
         errors++;
         $display("FAIL rst_mid_grant: gnt=%b, required 01", {gnt1, gnt0});
      end
      req0 = 1'b0;
      bad = 0;
      for (int s = 0; s < 50; s++) begin
         d = 2'($urandom_range(0, 3));
         drive(0, 1'b1, d);
         tick();
         if (axiov !== 1'b1 || axiod !== d) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rst_mid_stream: %0d dibits off, required 0", bad);
      end
      rst = 1'b1;
      drive(0, 1'b1, 2'b11);
      tick();
      checks++;
      if ({gnt0, gnt1, axiov, axiod, busy, err_trunc, err_tmo} !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid_outputs: got %b, required 00000000", {gnt0, gnt1, axiov, axiod, busy, err_trunc, err_tmo});
      end
      rst = 1'b0;
      drive(0, 1'b0, 2'b00);
      req0 = 1'b1;
      model_last = 1;
      run_pkt(30, -1, 1'b0, w);
      checks++;
      if (w != 1) begin
         errors++;
         $display("FAIL rst_mid_regrant: grant after %0d cycles, required 1", w);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_noise();
      test_timeout();
      test_trunc();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
